// File: rtl/noise_pkg.sv
// Shared sample width, lane type and saturation bounds for the noise scaler.
package noise_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam logic signed [SAMPLE_W:0] SAT_MAX = 17'sd32767;
  localparam logic signed [SAMPLE_W:0] SAT_MIN = -17'sd32768;

  // Clamp a one-bit-wider signed value into the 16-bit sample range.
  function automatic sample_t sat_sample(input logic signed [SAMPLE_W:0] v);
    sample_t r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[SAMPLE_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/noise_scale_lane.sv
// One lane: signed sample times unsigned Q0.SCALE_WIDTH amplitude, floor-shifted.
// With NOISE_SCALER_OFFSET_EN defined, adds a signed offset and saturates.
module noise_scale_lane
  import noise_pkg::*;
#(
  parameter int SCALE_WIDTH = 16
) (
  input  logic signed [SAMPLE_W-1:0]    sample_i,
  input  logic        [SCALE_WIDTH-1:0] scale_i,
`ifdef NOISE_SCALER_OFFSET_EN
  input  logic signed [SAMPLE_W-1:0]    offset_i,
`endif
  output logic        [SAMPLE_W-1:0]    result_o
);

  localparam int PROD_W = SAMPLE_W + SCALE_WIDTH + 1;

  logic signed [PROD_W-1:0] product_s;
  logic signed [SAMPLE_W:0] scaled_s;
  logic                     unused_bits_s;

  // Taking the upper product bits is the arithmetic (floor) shift by SCALE_WIDTH.
  always_comb begin
    product_s = PROD_W'(sample_i) * PROD_W'($signed({1'b0, scale_i}));
    scaled_s  = product_s[SCALE_WIDTH +: (SAMPLE_W + 1)];
  end

  assign unused_bits_s = ^{product_s[SCALE_WIDTH-1:0], scaled_s[SAMPLE_W]};

`ifdef NOISE_SCALER_OFFSET_EN
  logic signed [SAMPLE_W:0] sum_s;

  // The scaled value always fits 16 bits, so a 17-bit sum cannot overflow.
  always_comb begin
    sum_s    = scaled_s + (SAMPLE_W + 1)'(offset_i);
    result_o = sat_sample(sum_s);
  end
`else
  // Magnitude of the amplitude is below one, so the result never leaves 16 bits.
  always_comb begin
    result_o = scaled_s[SAMPLE_W-1:0];
  end
`endif

endmodule

// File: rtl/noise_scaler.sv
// Two-stage scaler for parallel LFSR noise with a global-stall output handshake.
// Optional NOISE_SCALER_OFFSET_EN adds a latched, saturating per-sample offset.
module noise_scaler
  import noise_pkg::*;
#(
  parameter int PARALLEL_SAMPLES = 4,
  parameter int SCALE_WIDTH      = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     run,
  input  logic [PARALLEL_SAMPLES-1:0][SAMPLE_W-1:0] lfsr_data,
  output logic                                     lfsr_enable,
  input  logic [SCALE_WIDTH-1:0]                   scale_data,
  input  logic                                     scale_valid,
  output logic                                     scale_ready,
`ifdef NOISE_SCALER_OFFSET_EN
  input  logic [SAMPLE_W-1:0]                      offset_data,
`endif
  output logic [PARALLEL_SAMPLES-1:0][SAMPLE_W-1:0] m_data,
  output logic                                     m_valid,
  input  logic                                     m_ready
);

  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic [SCALE_WIDTH-1:0] s1_scale_q, s1_scale_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [PARALLEL_SAMPLES-1:0][SAMPLE_W-1:0] s1_data_q, s1_data_d;
  logic                   m_valid_q, m_valid_d;
  logic [PARALLEL_SAMPLES-1:0][SAMPLE_W-1:0] m_data_q, m_data_d;
  logic [PARALLEL_SAMPLES-1:0][SAMPLE_W-1:0] lane_result_s;
  logic                   advance_s;
  logic                   scale_fire_s;

  assign advance_s    = !m_valid_q || m_ready;
  assign lfsr_enable  = run && advance_s && reset_n;
  assign scale_ready  = reset_n;
  assign scale_fire_s = scale_valid && scale_ready;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;

`ifdef NOISE_SCALER_OFFSET_EN
  logic [SAMPLE_W-1:0] offset_q, offset_d;
  logic [SAMPLE_W-1:0] s1_offset_q, s1_offset_d;

  // Offset follows the amplitude handshake and is sampled into S1 alongside it.
  always_comb begin
    offset_d    = offset_q;
    s1_offset_d = s1_offset_q;
    if (scale_fire_s) begin
      offset_d = offset_data;
    end else begin
      offset_d = offset_q;
    end
    if (advance_s && lfsr_enable) begin
      s1_offset_d = offset_q;
    end else begin
      s1_offset_d = s1_offset_q;
    end
  end

  // Offset registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offset_q    <= '0;
      s1_offset_q <= '0;
    end else begin
      offset_q    <= offset_d;
      s1_offset_q <= s1_offset_d;
    end
  end
`endif

  // S1 samples the amplitude register's old value, so a coincident handshake
  // only affects the following capture.
  always_comb begin
    scale_d    = scale_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_scale_d = s1_scale_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    if (scale_fire_s) begin
      scale_d = scale_data;
    end else begin
      scale_d = scale_q;
    end
    if (advance_s) begin
      s1_valid_d = lfsr_enable;
      m_valid_d  = s1_valid_q;
      if (lfsr_enable) begin
        s1_data_d  = lfsr_data;
        s1_scale_d = scale_q;
      end else begin
        s1_data_d  = s1_data_q;
        s1_scale_d = s1_scale_q;
      end
      if (s1_valid_q) begin
        m_data_d = lane_result_s;
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
      m_valid_d  = m_valid_q;
    end
  end

  // Pipeline and amplitude registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scale_q    <= '0;
      s1_scale_q <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      scale_q    <= scale_d;
      s1_scale_q <= s1_scale_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  for (genvar i = 0; i < PARALLEL_SAMPLES; i++) begin : g_lane
    noise_scale_lane #(
      .SCALE_WIDTH (SCALE_WIDTH)
    ) u_lane (
      .sample_i (s1_data_q[i]),
      .scale_i  (s1_scale_q),
`ifdef NOISE_SCALER_OFFSET_EN
      .offset_i (s1_offset_q),
`endif
      .result_o (lane_result_s[i])
    );
  end

endmodule

// File: tb/tb_noise_scaler.sv
// Bench for noise_scaler: random traffic against a queue-based reference plus
// directed literal cases; honours NOISE_SCALER_OFFSET_EN.
module tb_noise_scaler;

  localparam int N = 4;
`ifdef NOISE_SCALER_OFFSET_EN
  localparam bit OFFSET_EN = 1'b1;
`else
  localparam bit OFFSET_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              run;
  logic [N-1:0][15:0] lfsr_data;
  logic              lfsr_enable;
  logic [15:0]       scale_data;
  logic              scale_valid;
  logic              scale_ready;
  logic [15:0]       offset_data;
  logic [N-1:0][15:0] m_data;
  logic              m_valid;
  logic              m_ready;

  logic [63:0] lfsr_state = 64'h0123_4567_89ab_cdef;
  logic        ov_en;
  logic [15:0] ov_word;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  logic [15:0] scale_m;
  logic [15:0] offset_m;
  logic [63:0] md;
  logic [63:0] held;

  always #5 clk = ~clk;

  noise_scaler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .lfsr_data   (lfsr_data),
    .lfsr_enable (lfsr_enable),
    .scale_data  (scale_data),
    .scale_valid (scale_valid),
    .scale_ready (scale_ready),
`ifdef NOISE_SCALER_OFFSET_EN
    .offset_data (offset_data),
`endif
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready)
  );

  // Upstream parallel generator: advances only when the scaler asks for a word.
  function automatic logic [63:0] xorshift(input logic [63:0] s);
    logic [63:0] x;
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  always @(posedge clk) begin
    if (lfsr_enable) lfsr_state <= xorshift(lfsr_state);
  end

  assign lfsr_data = ov_en ? {N{ov_word}} : lfsr_state;

  // Reference: floor(lane * scale / 2^16) (+ offset, clamped when enabled).
  function automatic logic [15:0] ref_lane(input logic [15:0] x, input logic [15:0] s,
                                           input logic [15:0] off);
    longint p, q, r;
    p = longint'($signed(x)) * longint'(s);
    if (p >= 0) q = p / 65536;
    else        q = -((-p + 65535) / 65536);
    r = q + (OFFSET_EN ? longint'($signed(off)) : 64'sd0);
    if (OFFSET_EN && r > 32767)  r = 32767;
    if (OFFSET_EN && r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [63:0] ref_beat(input logic [63:0] w, input logic [15:0] s,
                                           input logic [15:0] off);
    logic [63:0] o;
    for (int k = 0; k < N; k++) o[16*k +: 16] = ref_lane(w[16*k +: 16], s, off);
    return o;
  endfunction

  task automatic check(input string name, input logic ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare process: sample well before each rising edge and predict its effect.
  always @(negedge clk) begin
    #2;
    md = m_data;
    if (!reset_n) begin
      exp_q.delete();
      scale_m  = 16'h0000;
      offset_m = 16'h0000;
      check("reset_outputs", (m_valid == 1'b0) && (lfsr_enable == 1'b0) &&
            (scale_ready == 1'b0) && (md == 64'h0),
            {md[31:0], 29'h0, m_valid, lfsr_enable, scale_ready}, 64'h0);
    end else begin
      check("enable_rule", lfsr_enable == (run && (!m_valid || m_ready)),
            lfsr_enable, run && (!m_valid || m_ready));
      check("scale_ready", scale_ready == 1'b1, scale_ready, 64'h1);
      check("occupancy", exp_q.size() <= (m_valid ? 2 : 1), exp_q.size(), m_valid ? 2 : 1);
      if (m_valid) begin
        check("beat_expected", exp_q.size() != 0, md, 64'h0);
        if (exp_q.size() != 0) begin
          check("beat_data", md == exp_q[0], md, exp_q[0]);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (lfsr_enable) exp_q.push_back(ref_beat(lfsr_data, scale_m, offset_m));
      if (scale_valid) begin
        scale_m  = scale_data;
        offset_m = offset_data;
      end
    end
  end

  task automatic one_beat(input logic [15:0] s, input logic [15:0] off,
                          input logic [15:0] w, input logic [63:0] exp, input string name);
    @(negedge clk);
    scale_valid = 1'b1; scale_data = s; offset_data = off;
    run = 1'b0; ov_en = 1'b1; ov_word = w;
    @(negedge clk);
    scale_valid = 1'b0; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    #3;
    check({name, "_valid"}, m_valid == 1'b1, m_valid, 64'h1);
    check(name, m_data == exp, m_data, exp);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; m_ready = 1'b1;
    scale_valid = 1'b0; scale_data = 16'h0000; offset_data = 16'h0000;
    ov_en = 1'b0; ov_word = 16'h0000;
    repeat (3) @(negedge clk);
    #3;
    check("in_reset", (m_valid == 1'b0) && (lfsr_enable == 1'b0) && (scale_ready == 1'b0),
          {m_valid, lfsr_enable, scale_ready}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    one_beat(16'h8000, 16'h0000, 16'hace1, 64'hd670_d670_d670_d670, "half_ace1");
    one_beat(16'hffff, 16'h0000, 16'hace1, 64'hace1_ace1_ace1_ace1, "full_ace1");
    one_beat(16'h0000, 16'h0000, 16'h8000, 64'h0, "zero_scale");
    one_beat(16'h8000, 16'h0000, 16'h4000, 64'h2000_2000_2000_2000, "half_4000");

    // Handshake coinciding with a capture: that beat keeps the old amplitude.
    @(negedge clk);
    ov_word = 16'h4000; run = 1'b1; scale_valid = 1'b1; scale_data = 16'hffff;
    @(negedge clk);
    scale_valid = 1'b0;
    @(negedge clk);
    run = 1'b0;
    #3;
    check("coincide_old", m_data[0] == 16'h2000, m_data[0], 64'h2000);
    @(negedge clk);
    #3;
    check("coincide_new", m_data[0] == 16'h3fff, m_data[0], 64'h3fff);

    // Five-cycle downstream stall while run stays high.
    @(negedge clk);
    ov_en = 1'b0; run = 1'b1; m_ready = 1'b1;
    repeat (4) @(negedge clk);
    m_ready = 1'b0;
    #3;
    held = m_data;
    check("stall_valid", m_valid == 1'b1, m_valid, 64'h1);
    for (int k = 0; k < 5; k++) begin
      #0;
      check("stall_enable", lfsr_enable == 1'b0, lfsr_enable, 64'h0);
      check("stall_hold", m_data == held, m_data, held);
      @(negedge clk);
      #3;
    end
    @(negedge clk);
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      run         = ($urandom_range(0, 9) < 8);
      m_ready     = ($urandom_range(0, 3) != 0);
      scale_valid = ($urandom_range(0, 11) == 0);
      scale_data  = 16'($urandom);
      offset_data = 16'($urandom);
    end
    @(negedge clk);
    run = 1'b0; m_ready = 1'b1; scale_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("drained", exp_q.size() == 0, exp_q.size(), 64'h0);

    // Reset pulse mid-stream.
    @(negedge clk);
    scale_valid = 1'b1; scale_data = 16'h9000; offset_data = 16'h0123; run = 1'b1;
    @(negedge clk);
    scale_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", m_valid == 1'b0, m_valid, 64'h0);
    check("rst_mid_enable", lfsr_enable == 1'b0, lfsr_enable, 64'h0);
    @(negedge clk);
    @(negedge clk);
    run = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    ov_en = 1'b1; ov_word = 16'h7fff; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    #3;
    check("post_rst_valid", m_valid == 1'b1, m_valid, 64'h1);
    check("post_rst_scale0", m_data == 64'h0, m_data, 64'h0);

    one_beat(16'hffff, 16'h7fff, 16'h4000,
             OFFSET_EN ? 64'h7fff_7fff_7fff_7fff : 64'h3fff_3fff_3fff_3fff, "offset_sat");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noise_scaler.md
NOISE_SCALER -- requirements
Module: noise_scaler

Interface
REQ-001 SHALL have parameter PARALLEL_SAMPLES, default 4: number of 16-bit lanes per beat.
REQ-002 SHALL have parameter SCALE_WIDTH, default 16: unsigned Q0.SCALE_WIDTH amplitude width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port run, input, 1 bit: permits new LFSR words to enter the pipeline.
REQ-006 SHALL have port lfsr_data, input, [PARALLEL_SAMPLES][16]: upstream parallel LFSR words.
REQ-007 SHALL have port lfsr_enable, output, 1 bit: advance strobe to the upstream LFSR.
REQ-008 SHALL have port scale_data, input, SCALE_WIDTH: new amplitude.
REQ-009 SHALL have port scale_valid, input, 1 bit: amplitude handshake valid.
REQ-010 SHALL have port scale_ready, output, 1 bit: amplitude handshake ready.
REQ-011 SHALL have port m_data, output, [PARALLEL_SAMPLES][16]: scaled signed samples.
REQ-012 SHALL have port m_valid, output, 1 bit: output valid.
REQ-013 SHALL have port m_ready, input, 1 bit: downstream ready.

Function
REQ-014 SHALL treat each lfsr_data lane as signed two's complement.
REQ-015 SHALL compute each lane as (lane * scale) >>> SCALE_WIDTH, with scale zero-extended, the product full-width signed and the shift arithmetic (floor).
REQ-016 SHALL use two register stages: S1 holds the captured LFSR word and scale; S2 holds the result, driving m_data/m_valid.
REQ-017 SHALL define advance = !m_valid || m_ready; S1→S2 and input→S1 move only on advance (global stall).
REQ-018 SHALL drive lfsr_enable = run && advance && reset_n, combinationally.
REQ-019 SHALL load S1 valid = lfsr_enable on each advance, so every LFSR word is consumed exactly once, with no drops or duplicates.
REQ-020 SHALL have latency: the word presented with lfsr_enable high at edge t appears on m_data after edge t+2 when m_ready stays high.
REQ-021 SHALL hold m_data stable while m_valid && !m_ready.
REQ-022 SHALL keep scale_ready = 1 at all times out of reset and 0 in reset; a scale handshake at edge t applies to words captured into S1 at edge t+1 onward.
REQ-023 SHALL give precedence to the sample capture at edge t when a scale handshake coincides with it: that sample uses the old scale.
REQ-024 SHALL, on run deasserting, drain S1/S2 normally; m_valid falls once the last beat is accepted.

Reset
REQ-025 SHALL, while reset_n is low, asynchronously clear S1/S2 valid, m_valid, m_data and the scale register to 0, and force lfsr_enable = 0.
REQ-026 SHALL discard any in-flight beats on reset mid-operation; after release, the first beat is the LFSR word present at the first enabled edge.

Configuration
REQ-027 SHALL, with NOISE_SCALER_OFFSET_EN defined, add input port offset_data (16 bits, signed), latched on the same handshake as scale_data and reset to 0.
REQ-028 SHALL, with NOISE_SCALER_OFFSET_EN defined, form the S2 result as the scaled value + offset saturated to [-32768, 32767], with latency unchanged.
REQ-029 SHALL, with NOISE_SCALER_OFFSET_EN undefined, omit the port and the adder; results are the unsaturated scaled values of REQ-015.

Structure
REQ-030 SHALL place the sample width (16), the lane typedef and the saturation bounds in shared package noise_pkg.
REQ-031 SHALL instantiate one sub-module per lane, noise_scale_lane, containing the multiply, shift and optional offset/saturate; pipeline and handshake control stay in noise_scaler.

Verification
REQ-032 SHALL verify: scale=16'h8000, lane0=16'hace1, m_ready=1 → m_data[0]=16'hd670, two cycles after lfsr_enable.
REQ-033 SHALL verify: scale=16'hffff, lane0=16'hace1 → 16'hace1; scale=0 → all lanes 16'h0000.
REQ-034 SHALL verify: m_ready low for 5 cycles with run=1 → lfsr_enable=0 throughout, m_data constant, no beat lost or repeated once m_ready returns (compare against a reference LFSR model).
REQ-035 SHALL verify: scale handshake on the same edge as a capture → that beat uses the old scale and the next beat uses the new one.
REQ-036 SHALL verify: reset_n pulsed low mid-stream → m_valid=0 and lfsr_enable=0 immediately; the scale reads 0 after release.
REQ-037 SHALL verify, with NOISE_SCALER_OFFSET_EN defined: scale=16'hffff, offset=16'h7fff, lane=16'h4000 → 16'h7fff (saturated).
